rf_wb_arbiter: RTL and testbench

Write-back arbiter that shares the register file's single write port between two producers: the ALU write-back path (A) and the memory/multi-cycle write-back path (B). Each producer hands over one write through a valid/ready handshake into a one-entry holding slot. The arbiter grants one slot per cycle and drives registered `writeaddr`/`writedata`/`regwrite` into the register file, which commits on the falling clock edge. It also exports a pending-write bitmap so decode can stall on outstanding writes.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_wb_slot.sv | 73 +++++++
 rtl/rf_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions for the write-back path.
// Optional feature macro used by the arbiter: RF_WB_RR_EN (round-robin tie-break).
package rf_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;
    localparam int RF_NREG = 32;

    // One register-file write: destination and payload.
    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

    // Identifies a requester slot (used by the round-robin history bit).
    typedef enum logic {
        SLOT_A = 1'b0,
        SLOT_B = 1'b1
    } rf_slot_e;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry holding slot for a write-back requester.
// Handshake: ready_o = !held | grant_i and never looks at valid_i; a transfer
// happens on a rising edge when valid_i & ready_o. Writes to register 0 are
// accepted but dropped. age_o = 1 marks this entry as younger than the other
// slot's entry.
module rf_wb_slot #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          grant_i,
    input  logic          other_stays_i,
    output logic          ready_o,
    output logic          occ_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    output logic          age_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          age_q, age_d;
    logic          accept;
    logic          load;

    assign ready_o = ~valid_q | grant_i;
    assign accept  = valid_i & ready_o;
    assign load    = accept & (addr_i != '0);

    // Next-state: free on grant, reload on a non-zero accept; a held entry
    // becomes the older one as soon as the other slot empties.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        age_d   = age_q & other_stays_i;
        if (grant_i) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
            age_d   = other_stays_i;
        end
    end

    // Slot state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            age_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            age_q   <= age_d;
        end
    end

    assign occ_o  = valid_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign age_o  = age_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two requesters share the register file's write port.
// Each requester fills a one-entry slot through valid/ready; one slot per
// cycle is granted and driven out through registered writeaddr/writedata/
// regwrite. Same-address contention always goes to the older entry.
// Optional macro RF_WB_RR_EN: round-robin between different-address slots;
// without it A always wins different-address contention.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW,
    parameter int CW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    input  logic [AW-1:0]      a_addr,
    input  logic [DW-1:0]      a_data,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [AW-1:0]      b_addr,
    input  logic [DW-1:0]      b_data,
    output logic               b_ready,
    output logic [AW-1:0]      writeaddr,
    output logic [DW-1:0]      writedata,
    output logic               regwrite,
    output logic [(1<<AW)-1:0] pending,
    output logic [CW-1:0]      stall_cnt
);

    logic          occ_a, occ_b;
    logic [AW-1:0] hold_a_addr, hold_b_addr;
    logic [DW-1:0] hold_a_data, hold_b_data;
    logic          age_a, age_b;
    logic          gnt_a, gnt_b;

    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] writeaddr_q, writeaddr_d;
    logic [DW-1:0] writedata_q, writedata_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [1:0]    stall_inc;
    logic [CW:0]   stall_sum;

`ifdef RF_WB_RR_EN
    rf_slot_e      last_q, last_d;
`endif

    rf_wb_slot #(.AW(AW), .DW(DW)) u_slot_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (a_valid),
        .addr_i        (a_addr),
        .data_i        (a_data),
        .grant_i       (gnt_a),
        .other_stays_i (occ_b & ~gnt_b),
        .ready_o       (a_ready),
        .occ_o         (occ_a),
        .addr_o        (hold_a_addr),
        .data_o        (hold_a_data),
        .age_o         (age_a)
    );

    rf_wb_slot #(.AW(AW), .DW(DW)) u_slot_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (b_valid),
        .addr_i        (b_addr),
        .data_i        (b_data),
        .grant_i       (gnt_b),
        .other_stays_i (occ_a & ~gnt_a),
        .ready_o       (b_ready),
        .occ_o         (occ_b),
        .addr_o        (hold_b_addr),
        .data_o        (hold_b_data),
        .age_o         (age_b)
    );

    // Grant at most one occupied slot; same address keeps program order.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (occ_a && occ_b) begin
            if (hold_a_addr == hold_b_addr) begin
                if (age_a && !age_b) begin
                    gnt_b = 1'b1;
                end else begin
                    gnt_a = 1'b1;
                end
            end else begin
`ifdef RF_WB_RR_EN
                if (last_q == SLOT_A) begin
                    gnt_b = 1'b1;
                end else begin
                    gnt_a = 1'b1;
                end
`else
                gnt_a = 1'b1;
`endif
            end
        end else if (occ_a) begin
            gnt_a = 1'b1;
        end else if (occ_b) begin
            gnt_b = 1'b1;
        end
    end

`ifdef RF_WB_RR_EN
    // Remember the winner of every two-slot grant so the other slot wins next.
    always_comb begin
        last_d = last_q;
        if (occ_a && occ_b) begin
            last_d = gnt_b ? SLOT_B : SLOT_A;
        end
    end

    // Round-robin history register; starts at B so A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= SLOT_B;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Output port and saturating stall counter next-state.
    always_comb begin
        regwrite_d  = gnt_a | gnt_b;
        writeaddr_d = writeaddr_q;
        writedata_d = writedata_q;
        if (gnt_a) begin
            writeaddr_d = hold_a_addr;
            writedata_d = hold_a_data;
        end else if (gnt_b) begin
            writeaddr_d = hold_b_addr;
            writedata_d = hold_b_data;
        end
        stall_inc = {1'b0, occ_a & ~gnt_a} + {1'b0, occ_b & ~gnt_b};
        stall_sum = {1'b0, stall_q} + {{(CW - 1){1'b0}}, stall_inc};
        stall_d   = stall_sum[CW] ? {CW{1'b1}} : stall_sum[CW-1:0];
    end

    // Register-file port and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            writeaddr_q <= '0;
            writedata_q <= '0;
            stall_q     <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            writeaddr_q <= writeaddr_d;
            writedata_q <= writedata_d;
            stall_q     <= stall_d;
        end
    end

    // Pending bitmap: held entries plus the write currently on the port.
    always_comb begin
        pending = '0;
        if (occ_a) begin
            pending[hold_a_addr] = 1'b1;
        end
        if (occ_b) begin
            pending[hold_b_addr] = 1'b1;
        end
        if (regwrite_q) begin
            pending[writeaddr_q] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign regwrite  = regwrite_q;
    assign writeaddr = writeaddr_q;
    assign writedata = writedata_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. Expected register-file writes are queued
// when stimulus is driven and popped by a falling-edge monitor that also keeps
// a model of the register file. Honours RF_WB_RR_EN for the expected order.
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               a_valid = 1'b0;
    logic [AW-1:0]      a_addr = '0;
    logic [DW-1:0]      a_data = '0;
    logic               a_ready;
    logic               b_valid = 1'b0;
    logic [AW-1:0]      b_addr = '0;
    logic [DW-1:0]      b_data = '0;
    logic               b_ready;
    logic [AW-1:0]      writeaddr;
    logic [DW-1:0]      writedata;
    logic               regwrite;
    logic [(1<<AW)-1:0] pending;
    logic [CW-1:0]      stall_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    rf_model[0:(1<<AW)-1];
    logic [CW-1:0]    exp_stall = '0;

    // Clock / reset
    always #5 clk = ~clk;

    rf_wb_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .writeaddr (writeaddr),
        .writedata (writedata),
        .regwrite  (regwrite),
        .pending   (pending),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Scoreboard: every regwrite must match the head of the expected queue.
    always @(negedge clk) begin
        if (regwrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", regwrite, 64'd0);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("sb_addr", writeaddr, e[AW+DW-1:DW]);
                chk("sb_data", writedata, e[DW-1:0]);
                rf_model[writeaddr] = writedata;
            end
        end
    end

    // Driver: A (addr 3) and B (addr 4) both request for n edges, n even.
    task automatic contend(input int n);
        int tmp;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
`ifdef RF_WB_RR_EN
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) push(5'd3, 32'h33);
            else            push(5'd4, 32'h44);
        end
        push(5'd3, 32'h33);
`else
        for (int i = 0; i < n; i++) push(5'd3, 32'h33);
        push(5'd4, 32'h44);
`endif
        for (int i = 0; i < n; i++) begin
            step();
            if (i < 3) begin
                chk("contend_stall_step", stall_cnt, exp_stall + 16'(i));
`ifdef RF_WB_RR_EN
                chk("rr_a_ready", a_ready, (i % 2 == 0) ? 64'd1 : 64'd0);
                chk("rr_b_ready", b_ready, (i % 2 == 0) ? 64'd0 : 64'd1);
`else
                chk("fp_a_ready", a_ready, 64'd1);
                chk("fp_b_ready", b_ready, 64'd0);
`endif
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (4) step();
        tmp = int'(exp_stall) + n;
        exp_stall = (tmp > 65535) ? 16'hFFFF : 16'(tmp);
        chk("contend_stall_total", stall_cnt, exp_stall);
        chk("contend_idle", regwrite, 64'd0);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_regwrite", regwrite, 64'd0);
        chk("rst_writeaddr", writeaddr, 64'd0);
        chk("rst_writedata", writedata, 64'd0);
        chk("rst_pending", pending, 64'd0);
        chk("rst_stall", stall_cnt, 64'd0);
        chk("rst_a_ready", a_ready, 64'd1);
        chk("rst_b_ready", b_ready, 64'd1);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Single write from A
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        chk("single_a_ready", a_ready, 64'd1);
        push(5'd5, 32'hDEADBEEF);
        step();
        a_valid = 1'b0;
        chk("single_pend_held", pending, 64'h20);
        chk("single_no_write_yet", regwrite, 64'd0);
        step();
        chk("single_regwrite", regwrite, 64'd1);
        chk("single_addr", writeaddr, 64'd5);
        chk("single_data", writedata, 64'hDEADBEEF);
        chk("single_pend_driven", pending, 64'h20);
        step();
        chk("single_regwrite_off", regwrite, 64'd0);
        chk("single_pend_clear", pending, 64'd0);
        chk("single_rf5", rf_model[5], 64'hDEADBEEF);
        chk("single_addr_hold", writeaddr, 64'd5);

        // Address 0 is swallowed
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1234;
        chk("zero_b_ready_pre", b_ready, 64'd1);
        step();
        b_valid = 1'b0;
        chk("zero_b_ready_post", b_ready, 64'd1);
        chk("zero_pending", pending, 64'd0);
        chk("zero_regwrite0", regwrite, 64'd0);
        step();
        chk("zero_regwrite1", regwrite, 64'd0);
        chk("zero_pending1", pending, 64'd0);

        // Different-address contention
        contend(6);

        // WAW ordering on register 7
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h1;
        push(5'd9, 32'h99);
        push(5'd7, 32'h1);
        push(5'd7, 32'h2);
        step();
        b_valid = 1'b0;
        a_addr = 5'd7; a_data = 32'h2;
        chk("waw_a_ready", a_ready, 64'd1);
        chk("waw_b_blocked", b_ready, 64'd0);
        step();
        a_valid = 1'b0;
        chk("waw_pending", pending, 64'h280);
        repeat (3) step();
        exp_stall = exp_stall + 16'd2;
        chk("waw_rf7", rf_model[7], 64'h2);
        chk("waw_rf9", rf_model[9], 64'h99);
        chk("waw_stall", stall_cnt, exp_stall);

        // Counter saturation
        contend(65546);
        chk("sat_stall", stall_cnt, 64'hFFFF);

        // Reset with both slots full
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hB;
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("mid_pending_full", pending, 64'h0C00);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_regwrite", regwrite, 64'd0);
        chk("mid_rst_writeaddr", writeaddr, 64'd0);
        chk("mid_rst_writedata", writedata, 64'd0);
        chk("mid_rst_pending", pending, 64'd0);
        chk("mid_rst_stall", stall_cnt, 64'd0);
        chk("mid_rst_a_ready", a_ready, 64'd1);
        chk("mid_rst_b_ready", b_ready, 64'd1);
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_regwrite", regwrite, 64'd0);
            chk("post_rst_pending", pending, 64'd0);
        end

        chk("sb_drained", exp_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
